// File: rtl/delayed_branch_ctrl.sv
// Delayed-branch sequencer: queues up to two delayed-branch records per bundle,
// ages them with the pipeline and resolves the head against N/V/Z at stage 3.
module delayed_branch_ctrl #(
    parameter int DEPTH       = 4,
    parameter int RESOLVE_AGE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       p0_push,
    input  logic [7:0] p0_dest,
    input  logic [2:0] p0_cond,
    input  logic       p1_push,
    input  logic [7:0] p1_dest,
    input  logic [2:0] p1_cond,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    input  logic       flags_valid,
    output logic       redirect_valid,
    output logic [8:0] redirect_pc,
    output logic       redirect_odd,
    output logic       flush,
    output logic       stall_req,
    output logic       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [1:0] AGE_MAX = 2'(RESOLVE_AGE);

    localparam logic [2:0] COND_NV = 3'd0;
    localparam logic [2:0] COND_AL = 3'd1;
    localparam logic [2:0] COND_EQ = 3'd2;
    localparam logic [2:0] COND_NE = 3'd3;
    localparam logic [2:0] COND_LT = 3'd4;
    localparam logic [2:0] COND_LE = 3'd5;
    localparam logic [2:0] COND_GT = 3'd6;
    localparam logic [2:0] COND_GE = 3'd7;

    logic [7:0]    q_dest [DEPTH];
    logic [2:0]    q_cond [DEPTH];
    logic [1:0]    q_age  [DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr, count, space, n_ripe;
    logic [PW-1:0] head, wa0, wa1;
    logic [DEPTH-1:0] slot_valid;
    logic          head_ready, resolve, cond_true, taken, lt_f;
    logic          v0, v1, w0, w1, drop;

    assign count      = wr_ptr - rd_ptr;
    assign head       = rd_ptr[PW-1:0];
    assign head_ready = (count != '0) && (q_age[head] == AGE_MAX);
    assign resolve    = head_ready & flags_valid;
    assign lt_f       = N ^ V;
    assign taken      = resolve & cond_true;

    always_comb begin
        cond_true = 1'b0;
        case (q_cond[head])
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = Z;
            COND_NE: cond_true = ~Z;
            COND_LT: cond_true = lt_f;
            COND_LE: cond_true = lt_f | Z;
            COND_GT: cond_true = ~Z & ~lt_f;
            COND_GE: cond_true = ~lt_f;
            default: cond_true = 1'b0;
        endcase
    end

    // A physical slot is live when its distance from the head is below the count.
    always_comb begin
        logic [PW-1:0] off;
        slot_valid = '0;
        n_ripe     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off           = PW'(i) - head;
            slot_valid[i] = ({1'b0, off} < count);
            if (slot_valid[i] && q_age[i] == AGE_MAX)
                n_ripe = n_ripe + (PW+1)'(1);
        end
    end

    assign stall_req = (head_ready & ~flags_valid) | (n_ripe >= (PW+1)'(2));

    // Room is judged after this edge's pop; p0 wins when only one slot is free.
    assign v0    = advance & p0_push & (p0_cond != COND_NV);
    assign v1    = advance & p1_push & (p1_cond != COND_NV);
    assign space = (PW+1)'(DEPTH) - count + (PW+1)'(resolve);
    assign w0    = v0 & ~taken & (space >= (PW+1)'(1));
    assign w1    = v1 & ~taken & (v0 ? (space >= (PW+1)'(2)) : (space >= (PW+1)'(1)));
    assign drop  = ~taken & ((v0 & ~w0) | (v1 & ~w1));
    assign wa0   = wr_ptr[PW-1:0];
    assign wa1   = wr_ptr[PW-1:0] + PW'(w0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            overflow       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            redirect_odd   <= 1'b0;
            flush          <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_dest[i] <= '0;
                q_cond[i] <= '0;
                q_age[i]  <= '0;
            end
        end else begin
            if (advance) begin
                for (int unsigned i = 0; i < DEPTH; i++)
                    if (slot_valid[i] && q_age[i] != AGE_MAX)
                        q_age[i] <= q_age[i] + 2'd1;
            end
            if (w0) begin
                q_dest[wa0] <= p0_dest;
                q_cond[wa0] <= p0_cond;
                q_age[wa0]  <= '0;
            end
            if (w1) begin
                q_dest[wa1] <= p1_dest;
                q_cond[wa1] <= p1_cond;
                q_age[wa1]  <= '0;
            end
            if (taken)
                rd_ptr <= wr_ptr;
            else
                rd_ptr <= rd_ptr + (PW+1)'(resolve);
            wr_ptr <= wr_ptr + (PW+1)'(w0) + (PW+1)'(w1);
            if (drop)
                overflow <= 1'b1;
            redirect_valid <= taken;
            flush          <= taken;
            redirect_pc    <= taken ? {1'b0, q_dest[head]} : '0;
            redirect_odd   <= taken & q_dest[head][0];
        end
    end
endmodule

// File: tb/tb_delayed_branch_ctrl.sv
// Scoreboard bench for delayed_branch_ctrl: expected redirect PCs are queued at
// stimulus time and consumed by a monitor whenever a redirect pulse appears.
module tb_delayed_branch_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       advance;
    logic       p0_push, p1_push;
    logic [7:0] p0_dest, p1_dest;
    logic [2:0] p0_cond, p1_cond;
    logic       N, V, Z, flags_valid;
    logic       redirect_valid, redirect_odd, flush, stall_req, overflow;
    logic [8:0] redirect_pc;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    delayed_branch_ctrl #(.DEPTH(4), .RESOLVE_AGE(2)) dut (
        .clk(clk), .rst(rst), .advance(advance),
        .p0_push(p0_push), .p0_dest(p0_dest), .p0_cond(p0_cond),
        .p1_push(p1_push), .p1_dest(p1_dest), .p1_cond(p1_cond),
        .N(N), .V(V), .Z(Z), .flags_valid(flags_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_odd(redirect_odd), .flush(flush),
        .stall_req(stall_req), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Monitor: every redirect pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            checks++;
            if (flush !== redirect_valid) begin
                errors++;
                $display("FAIL flush_coincident: flush=%b redirect_valid=%b", flush, redirect_valid);
            end
            if (redirect_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_redirect: got pc=%03h, expected none", redirect_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (redirect_pc !== e || redirect_odd !== e[0]) begin
                        errors++;
                        $display("FAIL redirect_pc: got pc=%03h odd=%b, expected pc=%03h odd=%b",
                                 redirect_pc, redirect_odd, e, e[0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_push = 0; p1_push = 0;
        p0_dest = '0; p1_dest = '0;
        p0_cond = '0; p1_cond = '0;
    endtask

    task automatic expect_rv(input string name, input logic exp);
        checks++;
        if (redirect_valid !== exp) begin
            errors++;
            $display("FAIL %s: redirect_valid=%b expected %b", name, redirect_valid, exp);
        end
    endtask

    task automatic expect_stall(input string name, input logic exp);
        checks++;
        if (stall_req !== exp) begin
            errors++;
            $display("FAIL %s: stall_req=%b expected %b", name, stall_req, exp);
        end
    endtask

    task automatic test_reset();
        rst = 0; advance = 0; idle();
        N = 0; V = 0; Z = 0; flags_valid = 0;
        #12;
        checks++;
        if ({redirect_valid, redirect_pc, redirect_odd, flush, stall_req, overflow} !== 14'd0) begin
            errors++;
            $display("FAIL reset_state: outputs=%b expected all zero",
                     {redirect_valid, redirect_pc, redirect_odd, flush, stall_req, overflow});
        end
        tick();
        rst = 1;
        tick();
    endtask

    // Push one record, advance through E0..E2, resolve at E3.
    task automatic run_single(input string name, input logic [2:0] cond, input logic [7:0] dest,
                              input logic n_f, input logic v_f, input logic z_f, input logic exp_taken);
        N = n_f; V = v_f; Z = z_f; flags_valid = 1; advance = 1;
        p0_push = 1; p0_cond = cond; p0_dest = dest;
        tick();                 // E0
        idle();
        tick();                 // E1
        tick();                 // E2
        expect_stall({name, "_stall"}, 1'b0);
        if (exp_taken) exp_q.push_back({1'b0, dest});
        tick();                 // E3
        expect_rv(name, exp_taken);
        tick();
        expect_rv({name, "_one_cycle"}, 1'b0);
    endtask

    task automatic test_beq();
        run_single("beq_taken", 3'd2, 8'h35, 0, 0, 1, 1);
        checks++;
        if (redirect_pc !== 9'h000 || flush !== 1'b0) begin
            errors++;
            $display("FAIL beq_after_pulse: pc=%03h flush=%b expected 000/0", redirect_pc, flush);
        end
    endtask

    task automatic test_not_taken();
        run_single("beq_not_taken", 3'd2, 8'h35, 0, 0, 0, 0);
    endtask

    task automatic test_conditions();
        logic [6:0] tbl [13];   // {cond, N, V, Z, taken}
        logic [6:0] t;
        tbl = '{ {3'd2,3'b001,1'b1}, {3'd3,3'b000,1'b1}, {3'd3,3'b001,1'b0},
                 {3'd4,3'b100,1'b1}, {3'd4,3'b110,1'b0}, {3'd5,3'b001,1'b1},
                 {3'd5,3'b000,1'b0}, {3'd6,3'b000,1'b1}, {3'd6,3'b010,1'b0},
                 {3'd7,3'b110,1'b1}, {3'd7,3'b100,1'b0}, {3'd1,3'b000,1'b1},
                 {3'd0,3'b001,1'b0} };
        for (int i = 0; i < 13; i++) begin
            t = tbl[i];
            run_single($sformatf("cond_%0d_case%0d", t[6:4], i), t[6:4], 8'h80 + 8'(i * 3),
                       t[3], t[2], t[1], t[0]);
        end
    endtask

    task automatic test_dual_push();
        N = 0; V = 0; Z = 1; flags_valid = 1; advance = 1;
        p0_push = 1; p0_cond = 3'd3; p0_dest = 8'h10;
        p1_push = 1; p1_cond = 3'd1; p1_dest = 8'h20;
        tick(); idle();         // E0
        tick();                 // E1
        tick();                 // E2
        expect_stall("dual_stall_both_ripe", 1'b1);
        advance = 0;
        tick();                 // E3: p0 NE not taken
        expect_rv("dual_p0_not_taken", 1'b0);
        expect_stall("dual_stall_released", 1'b0);
        exp_q.push_back(9'h020);
        tick();                 // E4: p1 AL taken
        expect_rv("dual_p1_taken", 1'b1);
        advance = 1;
        tick();
    endtask

    task automatic test_kill_younger();
        N = 0; V = 0; Z = 0; flags_valid = 1; advance = 1;
        p0_push = 1; p0_cond = 3'd1; p0_dest = 8'h40;
        tick(); idle();         // E0
        p1_push = 1; p1_cond = 3'd1; p1_dest = 8'h50;
        tick(); idle();         // E1
        tick();                 // E2
        exp_q.push_back(9'h040);
        tick();                 // E3
        expect_rv("kill_first_taken", 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_rv($sformatf("kill_no_second_%0d", i), 1'b0);
        end
    endtask

    task automatic test_flags_late();
        N = 0; V = 0; Z = 0; flags_valid = 0; advance = 1;
        p0_push = 1; p0_cond = 3'd7; p0_dest = 8'h7B;
        tick(); idle();         // E0
        tick();                 // E1
        tick();                 // E2
        advance = 0;
        for (int i = 0; i < 3; i++) begin
            expect_stall($sformatf("late_stall_%0d", i), 1'b1);
            expect_rv($sformatf("late_no_redirect_%0d", i), 1'b0);
            if (i < 2) tick();
        end
        flags_valid = 1;
        #1;
        expect_stall("late_stall_drop", 1'b0);
        exp_q.push_back(9'h07B);
        tick();
        expect_rv("late_resolved", 1'b1);
        advance = 1;
        tick();
    endtask

    task automatic test_overflow_and_reset();
        N = 0; V = 0; Z = 0; flags_valid = 0; advance = 1;
        p0_push = 1; p0_cond = 3'd1; p0_dest = 8'h01;
        p1_push = 1; p1_cond = 3'd1; p1_dest = 8'h02;
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_early: overflow=%b expected 0", overflow);
        end
        p0_dest = 8'h03; p1_dest = 8'h04;
        tick(); idle();
        p0_push = 1; p0_cond = 3'd1; p0_dest = 8'h05;
        tick(); idle();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: overflow=%b expected 1", overflow);
        end
        expect_stall("overflow_stall", 1'b1);
        advance = 0; flags_valid = 1;
        exp_q.push_back(9'h001);
        tick();
        expect_rv("overflow_head_taken", 1'b1);
        tick();
        expect_rv("overflow_rest_killed", 1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: overflow=%b expected 1", overflow);
        end
        // Bring a fresh record to the brink of resolution, then reset mid-cycle.
        flags_valid = 0; advance = 1;
        p0_push = 1; p0_cond = 3'd1; p0_dest = 8'h66;
        tick(); idle();
        tick();
        tick();
        advance = 0;
        expect_stall("pre_reset_stall", 1'b1);
        flags_valid = 1;
        rst = 0;
        #1;
        checks++;
        if ({redirect_valid, redirect_pc, redirect_odd, flush, stall_req, overflow} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: outputs=%b expected all zero",
                     {redirect_valid, redirect_pc, redirect_odd, flush, stall_req, overflow});
        end
        tick();
        expect_rv("reset_no_redirect", 1'b0);
        rst = 1;
        tick();
        expect_rv("post_reset_empty", 1'b0);
        expect_stall("post_reset_stall", 1'b0);
    endtask

    initial begin
        test_reset();
        test_beq();
        test_not_taken();
        test_conditions();
        test_dual_push();
        test_kill_younger();
        test_flags_late();
        test_overflow_and_reset();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d redirects still expected, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/delayed_branch_ctrl.md
# delayed_branch_ctrl

Sequencer for the delayed half of every decoded branch. Captures up to two delayed-branch records per fetch bundle (destination plus condition), ages them in step with the pipeline, and resolves each one against the N/V/Z flags at stage 3. When a delayed branch fires, it issues a one-cycle PC redirect plus pipeline flush, kills all younger pending records, and requests a stall while resolution is not yet possible.

## Interface
- DEPTH, 4: pending-record queue entries; power of two, ≥ 2.
- RESOLVE_AGE, 2: number of advance edges after capture at which a record becomes resolvable.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- advance  in  1  pipeline advance enable (fetch_next_in); capture and ageing happen only when 1.
- p0_push  in  1  slot-0 delayed record valid this bundle.
- p0_dest  in  8  slot-0 delayed destination.
- p0_cond  in  3  slot-0 delayed condition (NV=0, AL=1, EQ=2, NE=3, LT=4, LE=5, GT=6, GE=7).
- p1_push, p1_dest, p1_cond  in  1/8/3  slot-1 equivalents.
- N, V, Z  in  1 each  stage-3 flags.
- flags_valid  in  1  flags reflect all instructions older than the head record.
- redirect_valid  out  1  one-cycle pulse: take redirect_pc.
- redirect_pc  out  9  {1'b0, dest}.
- redirect_odd  out  1  dest[0]; downstream uses it to invalidate IR0.
- flush  out  1  one-cycle pulse, coincident with redirect_valid.
- stall_req  out  1  hold the pipeline (forces advance low externally).
- overflow  out  1  sticky error flag; cleared only by reset.

## Operation
- Queue: circular FIFO, DEPTH entries, fields {dest[7:0], cond[2:0], age[1:0]}. Write/read pointers are log2(DEPTH)+1 bits; the extra bit distinguishes full from empty.
- Capture happens on an advance=1 edge. A pushed record with cond==NV is discarded and never enters the queue.
- Ordering: p0 is older than p1. If both are pushed, p0 is written first. Both records enter with age 0.
- Ageing: on each advance=1 edge, every valid entry's age increments, saturating at RESOLVE_AGE.
- Resolution: only the head entry is evaluated, and only when age==RESOLVE_AGE and flags_valid=1. Let LT_f = N^V.
  - EQ → Z
  - NE → ~Z
  - LT → LT_f
  - LE → LT_f | Z
  - GT → ~Z & ~LT_f
  - GE → ~LT_f
  - AL → 1
- Not taken: the head is popped. There is no output pulse.
- Taken: the head is popped, all remaining entries are invalidated, any same-edge pushes are dropped, and redirect_valid and flush pulse for one cycle.
- stall_req = (head age==RESOLVE_AGE & ~flags_valid) | (two or more entries at age RESOLVE_AGE). This covers the case where both slots of one bundle reach stage 3 together; they resolve one per cycle, oldest first.
- Full: a push that does not fit after this cycle's pop is dropped and sets overflow. When only one slot fits, p0 is kept.

## Timing
- Reset values: queue empty, both pointers 0, redirect_valid=0, redirect_pc=0, redirect_odd=0, flush=0, stall_req=0, overflow=0.
- Reset is asynchronous: asserting rst low mid-resolution clears everything immediately, and no redirect is emitted.
- redirect_valid, flush, redirect_pc and redirect_odd are registered. They appear the cycle after the resolving edge and hold for exactly one cycle.
- Latency: capture edge E0, then advance edges E1 and E2 bring age to 2. With flags_valid=1, resolution occurs at edge E3 and redirect is visible during cycle E3..E4.
- stall_req is combinational from the queue state and flags_valid. It must not depend on advance, so there is no combinational loop.
- A simultaneous pop and push on the same edge is legal; the count changes by (pushes − pops). A taken pop overrides both.
- Pointer wrap-around modulo DEPTH is transparent.

## Test plan
- Single BEQ record: push p0 dest=0x35 cond=EQ, advance for 3 edges, Z=1, flags_valid=1 → redirect_valid pulse, redirect_pc=0x035, redirect_odd=1, flush=1, queue empty.
- Not taken: same stimulus with Z=0 → no redirect pulse; queue empty after the resolve edge.
- Dual push: p0 cond=NE dest=0x10, p1 cond=AL dest=0x20, Z=1 → stall_req=1 for one cycle; p0 not taken, then p1 gives redirect_pc=0x020.
- Kill younger: p0 cond=AL dest=0x40, a second bundle pushes p1 cond=AL dest=0x50 → only 0x040 is redirected; the 0x50 record is flushed and produces no second pulse.
- Flags late: head at age 2 with flags_valid=0 for 3 cycles → stall_req=1 for those 3 cycles, then resolution on the cycle flags_valid rises.
- Overflow and reset: push 5 AL records with advance held off after the first resolve, so the queue fills → overflow=1 and the fifth record is dropped. Drive rst low mid-stream → all outputs are 0 immediately.
